// File: rtl/chip8_call_ret_unit_pkg.sv
// Shared types and opcode constants for the Chip8 CALL/RET unit.
package chip8_call_ret_unit_pkg;

  // Command presented to Chip8_Stack; HOLD leaves the stack untouched.
  typedef enum logic [1:0] {
    STACK_HOLD = 2'd0,
    STACK_PUSH = 2'd1,
    STACK_POP  = 2'd2
  } STACK_OP;

  typedef enum logic [2:0] {
    CR_IDLE = 3'd0,
    CR_PUSH = 3'd1,
    CR_POP  = 3'd2,
    CR_WAIT = 3'd3,
    CR_LOAD = 3'd4,
    CR_ERR  = 3'd5
  } CALLRET_STATE;

  localparam logic [15:0] OPC_RET      = 16'h00EE;
  localparam logic [3:0]  OPC_CALL_NIB = 4'h2;

  // CALL is any 2NNN instruction.
  function automatic logic is_call(input logic [15:0] op);
    return op[15:12] == OPC_CALL_NIB;
  endfunction

endpackage

// File: rtl/chip8_call_ret_unit_stack_depth_tracker.sv
// Counts live stack entries; flags full/empty so the FSM can reject
// CALL on a full stack and RET on an empty one.
module chip8_stack_depth_tracker #(
  parameter int DEPTH = 16,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] depth,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] depth_reg;

  assign depth = depth_reg;
  assign full  = (depth_reg == W'(DEPTH));
  assign empty = (depth_reg == '0);

  // Saturating up/down count; the guards keep it in 0..DEPTH even if misdriven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_reg <= '0;
    end else if (inc && !full) begin
      depth_reg <= depth_reg + 1'b1;
    end else if (dec && !empty) begin
      depth_reg <= depth_reg - 1'b1;
    end
  end

endmodule

// File: rtl/chip8_call_ret_unit.sv
// CALL (2NNN) / RET (00EE) sequencer: drives Chip8_Stack commands and
// produces the PC load for the CPU. All outputs are registers updated
// together with the state, so there is no start-to-output path.
module chip8_call_ret_unit
  import chip8_call_ret_unit_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int POP_LATENCY = 1
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] opcode,
  input  logic [11:0] pc_in,
  output STACK_OP     stk_op,
  output logic [15:0] stk_writedata,
  input  logic [15:0] stk_outdata,
  output logic [11:0] pc_out,
  output logic        pc_load,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [4:0]  depth
);

  localparam int CW = (POP_LATENCY > 1) ? $clog2(POP_LATENCY) : 1;

  CALLRET_STATE  state_reg;
  logic [11:0]   target_reg;
  logic [CW-1:0] wait_cnt_reg;
  logic          full;
  logic          empty;

  // Stack returns the address in the low 12 bits; the top nibble carries nothing.
  logic unused_nib;
  assign unused_nib = ^stk_outdata[15:12];

  chip8_stack_depth_tracker #(
    .DEPTH (DEPTH),
    .W     (5)
  ) u_depth (
    .clk   (cpu_clk),
    .rst_n (reset),
    .inc   (state_reg == CR_PUSH),
    .dec   (state_reg == CR_POP),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // Control FSM with its outputs registered alongside the next state.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= CR_IDLE;
      target_reg    <= '0;
      wait_cnt_reg  <= '0;
      stk_op        <= STACK_HOLD;
      stk_writedata <= '0;
      pc_out        <= '0;
      pc_load       <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      stk_op        <= STACK_HOLD;
      stk_writedata <= '0;
      pc_out        <= '0;
      pc_load       <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      case (state_reg)
        CR_IDLE: begin
          if (start && is_call(opcode)) begin
            busy <= 1'b1;
            if (full) begin
              state_reg <= CR_ERR;
              err       <= 1'b1;
              done      <= 1'b1;
            end else begin
              state_reg     <= CR_PUSH;
              target_reg    <= opcode[11:0];
              stk_op        <= STACK_PUSH;
              stk_writedata <= {4'h0, pc_in + 12'd2};
            end
          end else if (start && opcode == OPC_RET) begin
            busy <= 1'b1;
            if (empty) begin
              state_reg <= CR_ERR;
              err       <= 1'b1;
              done      <= 1'b1;
            end else begin
              state_reg <= CR_POP;
              stk_op    <= STACK_POP;
            end
          end
        end
        CR_PUSH: begin
          state_reg <= CR_LOAD;
          pc_out    <= target_reg;
          pc_load   <= 1'b1;
          done      <= 1'b1;
        end
        CR_POP: begin
          state_reg    <= CR_WAIT;
          wait_cnt_reg <= CW'(POP_LATENCY - 1);
        end
        CR_WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg  <= CR_LOAD;
            target_reg <= stk_outdata[11:0];
            pc_out     <= stk_outdata[11:0];
            pc_load    <= 1'b1;
            done       <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        CR_LOAD, CR_ERR: begin
          state_reg <= CR_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= CR_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_call_ret_unit.sv
// Randomised bench for chip8_call_ret_unit with a behavioural Chip8_Stack
// and a queue-based model of call/return semantics.
module tb_chip8_call_ret_unit;
  import chip8_call_ret_unit_pkg::*;

  localparam int DEPTH   = 16;
  localparam int POP_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] opcode = '0;
  logic [11:0] pc_in = '0;
  STACK_OP     stk_op;
  logic [15:0] stk_writedata;
  logic [15:0] stk_outdata;
  logic [11:0] pc_out;
  logic        pc_load, done, busy, err;
  logic [4:0]  depth;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] model_q[$];

  chip8_call_ret_unit #(
    .DEPTH       (DEPTH),
    .POP_LATENCY (POP_LAT)
  ) dut (
    .cpu_clk       (clk),
    .reset         (rst_n),
    .start         (start),
    .opcode        (opcode),
    .pc_in         (pc_in),
    .stk_op        (stk_op),
    .stk_writedata (stk_writedata),
    .stk_outdata   (stk_outdata),
    .pc_out        (pc_out),
    .pc_load       (pc_load),
    .done          (done),
    .busy          (busy),
    .err           (err),
    .depth         (depth)
  );

  always #20 clk = ~clk;

  // Stand-in for Chip8_Stack: data valid one cycle after the POP edge,
  // with junk in the upper nibble that the unit must ignore.
  logic [15:0] stk_mem [0:31];
  int          stk_sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_sp      <= 0;
      stk_outdata <= '0;
    end else if (stk_op == STACK_PUSH && stk_sp < 32) begin
      stk_mem[stk_sp] <= stk_writedata;
      stk_sp          <= stk_sp + 1;
    end else if (stk_op == STACK_POP && stk_sp > 0) begin
      stk_outdata <= {4'($urandom_range(0, 15)), stk_mem[stk_sp-1][11:0]};
      stk_sp      <= stk_sp - 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One instruction: predict from the model, run it, compare.
  task automatic do_op(input logic [15:0] op, input logic [11:0] pc);
    int          kind;   // 0 ignored, 1 call, 2 ret, 3 error
    int          exp_lat, lat, n_push, n_pop;
    logic [11:0] exp_pc, ret, got_pc;
    logic [15:0] exp_wd, got_wd;
    logic        got_load, got_err, got_busy1;
    logic [4:0]  got_depth;
    exp_pc = '0; exp_wd = '0; exp_lat = 0;
    if (op[15:12] == 4'h2) begin
      if (model_q.size() == DEPTH) begin
        kind = 3; exp_lat = 1;
      end else begin
        kind = 1; exp_lat = 2;
        ret = pc + 12'd2;
        exp_wd = {4'h0, ret};
        exp_pc = op[11:0];
        model_q.push_back(ret);
      end
    end else if (op == 16'h00EE) begin
      if (model_q.size() == 0) begin
        kind = 3; exp_lat = 1;
      end else begin
        kind = 2; exp_lat = 2 + POP_LAT;
        exp_pc = model_q.pop_back();
      end
    end else begin
      kind = 0;
    end

    start = 1'b1; opcode = op; pc_in = pc;
    lat = 0; n_push = 0; n_pop = 0;
    got_pc = '0; got_wd = '0; got_load = 1'b0; got_err = 1'b0; got_busy1 = 1'b0; got_depth = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (stk_op == STACK_PUSH) begin n_push++; got_wd = stk_writedata; end
      if (stk_op == STACK_POP) n_pop++;
      if (c == 1) begin
        got_busy1 = busy;
        start  = (kind != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        opcode = 16'($urandom);
        pc_in  = 12'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = c; got_pc = pc_out; got_load = pc_load; got_err = err; got_depth = depth;
        break;
      end
      if (kind == 0 && c == 4) break;
    end
    @(posedge clk);
    #1 start = 1'b0; opcode = '0;

    check_val("latency", lat, exp_lat);
    check_val("push_count", n_push, (kind == 1) ? 1 : 0);
    check_val("pop_count", n_pop, (kind == 2) ? 1 : 0);
    check_val("busy", {31'b0, got_busy1}, (kind != 0) ? 1 : 0);
    if (kind == 1) check_val("push_data", {16'b0, got_wd}, {16'b0, exp_wd});
    if (kind != 0) begin
      check_val("pc_out", {20'b0, got_pc}, {20'b0, exp_pc});
      check_val("pc_load", {31'b0, got_load}, (kind == 3) ? 0 : 1);
      check_val("err", {31'b0, got_err}, (kind == 3) ? 1 : 0);
      check_val("depth", {27'b0, got_depth}, model_q.size());
    end
    @(negedge clk);
    check_val("done_one_cycle", {31'b0, done}, 0);
    check_val("idle_after", {31'b0, busy}, 0);
    $display("op=%h pc=%h kind=%0d lat=%0d pc_out=%h err=%0b depth=%0d", op, pc, kind, lat, got_pc, got_err, got_depth);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_stk_op"}, 32'(stk_op), 32'(STACK_HOLD));
    check_val({tag, "_busy"}, {31'b0, busy}, 0);
    check_val({tag, "_depth"}, {27'b0, depth}, 0);
    check_val({tag, "_outs"}, {stk_writedata, pc_out, pc_load, done, err, 1'b0}, 0);
  endtask

  initial begin
    int sel;
    logic [15:0] op;
    logic [3:0]  nib;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-PUSH
    start = 1'b1; opcode = 16'h2ABC; pc_in = 12'h010;
    @(negedge clk);
    start = 1'b0;
    check_val("pre_reset_push", 32'(stk_op), 32'(STACK_PUSH));
    #5 rst_n = 1'b0;
    #2 check_reset_outputs("async_reset");
    model_q.delete();
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset mid-push: depth=%0d busy=%0b", depth, busy);

    // Directed sequences
    do_op(16'h2345, 12'h200);
    do_op(16'h00EE, 12'h345);
    do_op(16'h2111, 12'h100);
    do_op(16'h2222, 12'h300);
    do_op(16'h2333, 12'hF00);
    repeat (3) do_op(16'h00EE, 12'h000);
    do_op(16'h2456, 12'hFFE);
    do_op(16'h00EE, 12'h456);
    do_op(16'h00EE, 12'h000);
    for (int i = 0; i <= DEPTH; i++) do_op({4'h2, 12'($urandom)}, 12'($urandom));
    do_op(16'h1234, 12'h050);
    repeat (DEPTH) do_op(16'h00EE, 12'($urandom));

    // Random mix
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        op = {4'h2, 12'($urandom)};
      end else if (sel < 9) begin
        op = 16'h00EE;
      end else begin
        nib = 4'($urandom_range(3, 15));
        op = {nib, 12'($urandom)};
      end
      do_op(op, 12'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
